// File: rtl/frame_buffer_pkg.sv
// Shared constants for the scaled Hack frame buffer: default colours,
// clear-engine state encoding and read-pipeline latency.
package frame_buffer_pkg;

  localparam logic [2:0] FG_DEFAULT     = 3'b111;
  localparam logic [2:0] BG_DEFAULT     = 3'b000;
  localparam logic [2:0] BORDER_DEFAULT = 3'b001;

  localparam int PIPE_LAT = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port synchronous screen RAM; a same-address read and write
// in one cycle returns the old word.
module fb_ram #(
  parameter int ADDR_W = 13,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register is resettable; the array itself is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_rdata <= '0;
    else        o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/frame_buffer_scaled.sv
// Hack frame buffer: maps the VGA beam onto a 1x/2x window, reads the screen
// RAM with a fixed 2-cycle latency and runs a clear engine on the write port.
module frame_buffer_scaled
  import frame_buffer_pkg::*;
#(
  parameter int                 H_START      = 144,
  parameter int                 V_START      = 112,
  parameter int                 SRC_W        = 512,
  parameter int                 SRC_H        = 256,
  parameter int                 WORD_W       = 16,
  parameter int                 ADDR_W       = 13,
  parameter int                 SCALE        = 1,
  parameter int                 COLOR_W      = 3,
  parameter logic [COLOR_W-1:0] FG_COLOR     = COLOR_W'(FG_DEFAULT),
  parameter logic [COLOR_W-1:0] BG_COLOR     = COLOR_W'(BG_DEFAULT),
  parameter logic [COLOR_W-1:0] BORDER_COLOR = COLOR_W'(BORDER_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  write_address,
  input  logic [WORD_W-1:0]  data_in,
  input  logic               load,
  output logic               write_ready,
  input  logic               clear_req,
  output logic               clear_busy,
  input  logic               invert,
  input  logic [10:0]        vga_h,
  input  logic [10:0]        vga_v,
  input  logic               overlay_on,
  input  logic [COLOR_W-1:0] overlay_pixel,
  output logic [COLOR_W-1:0] pixel_out
);

  localparam int          SHIFT = (SCALE == 2) ? 1 : 0;
  localparam int          BW    = $clog2(WORD_W);
  localparam int          WPR   = SRC_W / WORD_W;
  localparam logic [10:0] H0    = 11'(H_START);
  localparam logic [10:0] V0    = 11'(V_START);
  localparam logic [11:0] H_LO  = 12'(H_START);
  localparam logic [11:0] V_LO  = 12'(V_START);
  localparam logic [11:0] H_HI  = 12'(H_START + SRC_W * SCALE);
  localparam logic [11:0] V_HI  = 12'(V_START + SRC_H * SCALE);
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  // ---------------- coordinate mapping ----------------
  logic              w_in_win;
  logic [10:0]       w_dh, w_dv;
  logic [31:0]       w_x, w_y;
  logic [ADDR_W-1:0] w_raddr;
  logic [BW-1:0]     w_bit;

  assign w_in_win = ({1'b0, vga_h} >= H_LO) && ({1'b0, vga_h} < H_HI) &&
                    ({1'b0, vga_v} >= V_LO) && ({1'b0, vga_v} < V_HI);
  // Underflow outside the window is harmless: in_win masks the result.
  assign w_dh    = vga_h - H0;
  assign w_dv    = vga_v - V0;
  assign w_x     = 32'(w_dh >> SHIFT);
  assign w_y     = 32'(w_dv >> SHIFT);
  assign w_raddr = ADDR_W'(w_y * WPR + w_x / WORD_W);
  assign w_bit   = BW'(w_x % WORD_W);

  // ---------------- read pipeline ----------------
  logic [ADDR_W-1:0]  r_s0_addr;
  logic [BW-1:0]      r_s0_bit, r_s1_bit;
  logic               r_s0_win, r_s1_win;
  logic               r_s0_ov_on, r_s1_ov_on;
  logic [COLOR_W-1:0] r_s0_ov_px, r_s1_ov_px;
  logic [COLOR_W-1:0] r_pixel;
  logic               r_invert;
  logic [WORD_W-1:0]  w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_addr  <= '0;
      r_s0_bit   <= '0;
      r_s0_win   <= 1'b0;
      r_s0_ov_on <= 1'b0;
      r_s0_ov_px <= '0;
      r_s1_bit   <= '0;
      r_s1_win   <= 1'b0;
      r_s1_ov_on <= 1'b0;
      r_s1_ov_px <= '0;
      r_pixel    <= '0;
      r_invert   <= 1'b0;
    end else begin
      r_s0_addr  <= w_raddr;
      r_s0_bit   <= w_bit;
      r_s0_win   <= w_in_win;
      r_s0_ov_on <= overlay_on;
      r_s0_ov_px <= overlay_pixel;
      r_s1_bit   <= r_s0_bit;
      r_s1_win   <= r_s0_win;
      r_s1_ov_on <= r_s0_ov_on;
      r_s1_ov_px <= r_s0_ov_px;
      if (r_s1_win)
        r_pixel <= (w_rdata[r_s1_bit] ^ r_invert) ? FG_COLOR : BG_COLOR;
      else if (r_s1_ov_on)
        r_pixel <= r_s1_ov_px;
      else
        r_pixel <= BORDER_COLOR;
      // Frame-synchronous: invert only changes at the top-left beam position.
      if (vga_h == '0 && vga_v == '0) r_invert <= invert;
    end
  end

  assign pixel_out = r_pixel;

  // ---------------- clear engine ----------------
  clr_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WORD_W-1:0] w_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == ST_CLEAR) ? r_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = load;
    w_waddr     = write_address;
    w_wdata     = data_in;
    case (r_state)
      ST_IDLE:  if (clear_req) w_state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = '0;
        if (r_cnt == CNT_MAX) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign clear_busy  = (r_state == ST_CLEAR);
  assign write_ready = ~clear_busy;

  fb_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_s0_addr),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_frame_buffer_scaled.sv
// Scoreboard bench: a 1x and a 2x instance share all inputs; expected colours
// come from a behavioural screen model and are checked PIPE_LAT cycles later.
module tb_frame_buffer_scaled;
  import frame_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] write_address = '0;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic        clear_req = 1'b0;
  logic        invert = 1'b0;
  logic [10:0] vga_h = 11'd1;
  logic [10:0] vga_v = 11'd1;
  logic        overlay_on = 1'b0;
  logic [2:0]  overlay_pixel = '0;
  logic        write_ready1, write_ready2, clear_busy1, clear_busy2;
  logic [2:0]  pixel_out1, pixel_out2;

  always #5 clk = ~clk;

  frame_buffer_scaled #(.SCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .write_address(write_address), .data_in(data_in),
    .load(load), .write_ready(write_ready1), .clear_req(clear_req),
    .clear_busy(clear_busy1), .invert(invert), .vga_h(vga_h), .vga_v(vga_v),
    .overlay_on(overlay_on), .overlay_pixel(overlay_pixel), .pixel_out(pixel_out1)
  );

  frame_buffer_scaled #(.SCALE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .write_address(write_address), .data_in(data_in),
    .load(load), .write_ready(write_ready2), .clear_req(clear_req),
    .clear_busy(clear_busy2), .invert(invert), .vga_h(vga_h), .vga_v(vga_v),
    .overlay_on(overlay_on), .overlay_pixel(overlay_pixel), .pixel_out(pixel_out2)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [15:0] m_mem [8192];
  logic        m_inv = 1'b0;

  function automatic logic [2:0] mdl(input int h, input int v, input logic ovon,
                                     input logic [2:0] ovpx, input int sc);
    int x, y, a, b;
    if (h >= 144 && h < 144 + 512*sc && v >= 112 && v < 112 + 256*sc) begin
      x = (h - 144) / sc;
      y = (v - 112) / sc;
      a = y*32 + x/16;
      b = x % 16;
      return (m_mem[a][b] ^ m_inv) ? 3'b111 : 3'b000;
    end
    return ovon ? ovpx : 3'b001;
  endfunction

  // ---------------- scoreboard ----------------
  logic [2:0]        q1[$], q2[$];
  string             tq[$];
  logic              drv_vld = 1'b0;
  logic [PIPE_LAT:0] vld_pipe = '0;

  always @(posedge clk) vld_pipe <= {vld_pipe[PIPE_LAT-1:0], drv_vld};

  always @(negedge clk) begin
    if (vld_pipe[PIPE_LAT]) begin
      if (q1.size() == 0) chk("sb_depth", q1.size(), 1);
      else begin
        string t;
        t = tq.pop_front();
        chk({t, "_x1"}, pixel_out1, q1.pop_front());
        chk({t, "_x2"}, pixel_out2, q2.pop_front());
      end
    end
  end

  task automatic pix(input string tag, input int h, input int v,
                     input logic ovon, input logic [2:0] ovpx);
    @(negedge clk);
    vga_h = 11'(h); vga_v = 11'(v);
    overlay_on = ovon; overlay_pixel = ovpx;
    drv_vld = 1'b1;
    if (h == 0 && v == 0) m_inv = invert;
    q1.push_back(mdl(h, v, ovon, ovpx, 1));
    q2.push_back(mdl(h, v, ovon, ovpx, 2));
    tq.push_back(tag);
  endtask

  task automatic flush();
    @(negedge clk);
    drv_vld = 1'b0; vga_h = 11'd1; vga_v = 11'd1; overlay_on = 1'b0;
    #1;
    for (int i = 0; i < 8 && q1.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    chk("flush", q1.size(), 0);
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    write_address = 13'(a); data_in = d; load = 1'b1;
    m_mem[a] = d;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    chk("rst_pix", pixel_out1, 0);
    chk("rst_busy", clear_busy1, 0);
    chk("rst_ready", write_ready1, 1);
    chk("rst_ready2", write_ready2, 1);
    @(negedge clk) rst_n = 1'b1;

    // fill, then full clear
    for (int a = 0; a < 8192; a++) wr(a, 16'hFFFF);
    clr_pulse();
    n = 0;
    while (clear_busy1 === 1'b1 && n < 9000) begin
      n++;
      if (n == 1) begin
        chk("clr_ready", write_ready1, 0);
        chk("clr_busy2", clear_busy2, 1);
      end
      if (n == 6000) begin load = 1'b1; write_address = 13'd10; data_in = 16'hAAAA; end
      if (n == 6001) load = 1'b0;
      if (n == 7000) clear_req = 1'b1;
      if (n == 7001) clear_req = 1'b0;
      @(posedge clk); #1;
    end
    chk("clr_len", n, 8192);
    for (int a = 0; a < 8192; a++) m_mem[a] = '0;
    pix("clr_w0", 144, 112, 0, 0);
    pix("clr_w10", 304, 112, 0, 0);
    pix("clr_mid", 400, 300, 1, 3'b100);
    pix("clr_end", 655, 367, 0, 0);
    pix("clr_x2", 1000, 600, 0, 0);
    flush();

    // basic mapping and boundaries
    wr(0, 16'h0001);
    wr(31, 16'h8000);
    pix("first", 144, 112, 0, 0);
    pix("bit1", 145, 112, 0, 0);
    pix("left_bd", 143, 112, 0, 0);
    pix("last_col", 655, 112, 0, 0);
    pix("right_bd", 656, 112, 0, 0);
    pix("row1", 144, 113, 0, 0);
    pix("last_row", 144, 367, 0, 0);
    pix("bot_bd", 144, 368, 0, 0);
    pix("x2_corner", 1167, 623, 0, 0);
    pix("x2_bd", 1168, 112, 0, 0);
    flush();

    // 2x replication
    wr(0, 16'h0002);
    pix("s2_a", 146, 112, 0, 0);
    pix("s2_b", 147, 112, 0, 0);
    pix("s2_c", 146, 113, 0, 0);
    pix("s2_d", 147, 113, 0, 0);
    pix("s2_e", 145, 112, 0, 0);
    flush();

    // overlay
    pix("ov_bd", 10, 10, 1, 3'b100);
    pix("ov_win", 200, 200, 1, 3'b100);
    pix("ov_win2", 146, 112, 1, 3'b100);
    pix("ov_off", 10, 10, 0, 3'b100);
    flush();

    // invert: mid-frame request has no effect until the frame origin
    invert = 1'b1;
    pix("inv_mid_a", 144, 112, 0, 0);
    pix("inv_mid_b", 145, 112, 0, 0);
    flush();
    pix("inv_sync", 0, 0, 0, 0);
    flush();
    pix("inv_a", 144, 112, 0, 0);
    pix("inv_b", 145, 112, 0, 0);
    pix("inv_bd", 143, 112, 0, 0);
    flush();
    invert = 1'b0;
    pix("uninv_sync", 0, 0, 0, 0);
    flush();

    // reset in the middle of a clear
    for (int a = 0; a < 256; a++) wr(a, 16'hFFFF);
    clr_pulse();
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", clear_busy1, 0);
    chk("rst_mid_ready", write_ready1, 1);
    chk("rst_mid_pix", pixel_out1, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int a = 0; a < 100; a++) m_mem[a] = '0;
    pix("pc_w0", 144, 112, 0, 0);
    pix("pc_w99", 192, 115, 0, 0);
    pix("pc_w100", 208, 115, 0, 0);
    pix("pc_w200", 272, 118, 0, 0);
    flush();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
